// File: rtl/speed_test_sequencer_pkg.sv
// Shared speed-tester types: per-port config/result words, sequencer state,
// register map offsets and a byte-strobe merge helper.
package tester_common;

  typedef logic [15:0] u16_t;
  typedef logic [31:0] u32_t;

  // Eight config words and four result words per port, word 0 in the low bits.
  typedef logic [7:0][31:0] port_config_t;
  typedef logic [3:0][31:0] port_result_t;

  typedef enum logic [1:0] {
    ST_WAIT_READY = 2'd0,
    ST_IDLE       = 2'd1,
    ST_RUNNING    = 2'd2,
    ST_DRAINING   = 2'd3
  } test_seq_state_t;

  localparam logic [9:0] REG_STATUS    = 10'h000;
  localparam logic [9:0] REG_CONTROL   = 10'h004;
  localparam logic [9:0] REG_DURATION  = 10'h008;
  localparam logic [9:0] REG_WAIT      = 10'h00C;
  localparam logic [9:0] REG_PORT_MASK = 10'h010;
  localparam logic [9:0] REG_ELAPSED   = 10'h014;
  localparam logic [9:0] REG_RUN_COUNT = 10'h018;

  function automatic u32_t apply_strb(input u32_t old, input u32_t wdata, input logic [3:0] strb);
    u32_t r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/speed_test_sequencer_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the sequencer (slave).
interface speed_test_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/speed_test_sequencer_axil_reg_slave.sv
// AXI4-Lite handshake engine: turns bus transactions into a one-cycle write
// strobe and a read request whose data the owner returns on the next cycle.
module axil_reg_slave #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  speed_test_sequencer_if.slave s,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [DATA_W-1:0]   rd_data_i
);
  logic wrdy_q, bvalid_q, ardy_q, rvalid_q;
  logic unused_prot;

  assign unused_prot = ^{s.awprot, s.arprot};

  // Valids are held by the master, so the accept cycle still sees them high.
  assign wr_en_o   = wrdy_q & s.awvalid & s.wvalid;
  assign wr_addr_o = s.awaddr;
  assign wr_data_o = s.wdata;
  assign wr_strb_o = s.wstrb;
  assign rd_en_o   = ardy_q & s.arvalid;
  assign rd_addr_o = s.araddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrdy_q   <= 1'b0;
      bvalid_q <= 1'b0;
      ardy_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wrdy_q <= s.awvalid & s.wvalid & ~wrdy_q & ~bvalid_q;
      if (wr_en_o)       bvalid_q <= 1'b1;
      else if (s.bready) bvalid_q <= 1'b0;
      ardy_q <= s.arvalid & ~ardy_q & ~rvalid_q;
      if (rd_en_o)       rvalid_q <= 1'b1;
      else if (s.rready) rvalid_q <= 1'b0;
    end
  end

  assign s.awready = wrdy_q;
  assign s.wready  = wrdy_q;
  assign s.bresp   = 2'b00;
  assign s.bvalid  = bvalid_q;
  assign s.arready = ardy_q;
  assign s.rdata   = rd_data_i;
  assign s.rresp   = 2'b00;
  assign s.rvalid  = rvalid_q;
endmodule

// File: rtl/speed_test_sequencer.sv
// Speed-test sequencer: register map, per-port config/results and the timed
// run FSM. Define SPEED_TEST_ABORT_EN to enable CONTROL.abort.
module speed_test_sequencer
  import tester_common::*;
#(
  parameter int TEST_PORT_NUM      = 4,
  parameter int CLOCK_FREQ         = 125000000,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  speed_test_sequencer_if.slave                 s_axi,
  input  logic         [TEST_PORT_NUM-1:0]      gen_ready,
  input  logic         [TEST_PORT_NUM-1:0]      check_ready,
  input  port_result_t [TEST_PORT_NUM-1:0]      check_results,
  output logic         [TEST_PORT_NUM-1:0]      start,
  output logic         [TEST_PORT_NUM-1:0]      stop,
  output port_config_t [TEST_PORT_NUM-1:0]      port_config
);
  localparam int CYCLE_PER_MS = CLOCK_FREQ / 1000;
  localparam int CYC_W = (CYCLE_PER_MS > 1) ? $clog2(CYCLE_PER_MS) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLE_PER_MS - 1);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef logic [TEST_PORT_NUM-1:0] mask_t;

  logic            wr_en, rd_en;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_strb;
  u32_t            rd_mux, rd_data_q;
  logic [9:0]      wa, ra;
  logic            unused_addr;

  axil_reg_slave #(.ADDR_W(AW), .DATA_W(DW)) u_axil (
    .clk       (clk),
    .rst       (rst),
    .s         (s_axi),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data_q)
  );

  assign wa = {wr_addr[9:2], 2'b00};
  assign ra = {rd_addr[9:2], 2'b00};
  assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0]};

  test_seq_state_t state_q, state_d;
  u16_t            dur_q, dur_d, wait_q, wait_d, elapsed_q, elapsed_d, drain_q, drain_d;
  mask_t           mask_q, mask_d, act_q, act_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  u32_t            runs_q, runs_d;
  logic            aborted_q, aborted_d, rej_q, rej_d;
  port_config_t [TEST_PORT_NUM-1:0] cfg_q, cfg_d;
  port_result_t [TEST_PORT_NUM-1:0] res_q, res_d;

  logic ctrl_wr, start_req, abort_req, busy, tick, start_ok, dur_done, drain_done, all_ready;
  u16_t drain_target;

  assign ctrl_wr   = wr_en && (wa == REG_CONTROL);
  assign start_req = ctrl_wr & wr_data[0];
`ifdef SPEED_TEST_ABORT_EN
  assign abort_req = ctrl_wr & wr_data[1];
`else
  assign abort_req = 1'b0;
`endif
  assign busy         = (state_q != ST_IDLE);
  assign tick         = (cyc_q == CYC_LAST);
  assign start_ok     = (dur_q != '0) && (mask_q != '0);
  assign drain_target = (wait_q == '0) ? 16'd1 : wait_q;
  assign dur_done     = tick && (u16_t'(elapsed_q + 16'd1) == dur_q);
  assign drain_done   = tick && (u16_t'(drain_q + 16'd1) == drain_target);
  // Ports outside the active set do not hold up the return to IDLE.
  assign all_ready    = ((gen_ready & check_ready) | ~act_q) == '1;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT_READY;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_READY: if (all_ready)               state_d = ST_IDLE;
      ST_IDLE:       if (start_req && start_ok)   state_d = ST_RUNNING;
      ST_RUNNING:    if (abort_req || dur_done)   state_d = ST_DRAINING;
      ST_DRAINING:   if (abort_req || drain_done) state_d = ST_WAIT_READY;
      default:                                    state_d = ST_WAIT_READY;
    endcase
  end

  // FSM: outputs, decoded straight from state so reset clears them at once
  always_comb begin
    start = '0;
    stop  = '0;
    if (state_q == ST_RUNNING)  start = act_q;
    if (state_q == ST_DRAINING) stop  = act_q;
  end

  assign port_config = cfg_q;

  always_comb begin
    dur_d     = dur_q;
    wait_d    = wait_q;
    mask_d    = mask_q;
    act_d     = act_q;
    elapsed_d = elapsed_q;
    drain_d   = drain_q;
    cyc_d     = cyc_q;
    runs_d    = runs_q;
    aborted_d = aborted_q;
    rej_d     = rej_q;
    cfg_d     = cfg_q;
    res_d     = res_q;

    if (wr_en && !busy) begin
      if (wa == REG_DURATION)  dur_d  = u16_t'(apply_strb(u32_t'(dur_q), wr_data, wr_strb));
      if (wa == REG_WAIT)      wait_d = u16_t'(apply_strb(u32_t'(wait_q), wr_data, wr_strb));
      if (wa == REG_PORT_MASK) mask_d = mask_t'(apply_strb(u32_t'(mask_q), wr_data, wr_strb));
      for (int i = 0; i < TEST_PORT_NUM; i++)
        if (wa[9:8] == 2'b01 && wa[7:5] == 3'(i))
          cfg_d[i][wa[4:2]] = apply_strb(cfg_q[i][wa[4:2]], wr_data, wr_strb);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (start_ok) begin
            act_d     = mask_q;
            elapsed_d = '0;
            cyc_d     = '0;
            aborted_d = 1'b0;
            rej_d     = 1'b0;
            res_d     = '0;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_RUNNING, ST_DRAINING: begin
        cyc_d = tick ? '0 : cyc_q + 1'b1;
        for (int i = 0; i < TEST_PORT_NUM; i++)
          if (act_q[i]) res_d[i] = check_results[i];
        if (abort_req) begin
          aborted_d = 1'b1;
          cyc_d     = '0;
          drain_d   = '0;
        end else if (state_q == ST_RUNNING) begin
          if (tick) elapsed_d = elapsed_q + 16'd1;
          if (dur_done) drain_d = '0;
        end else if (drain_done) begin
          if (!aborted_q) runs_d = runs_q + 32'd1;
        end else if (tick) begin
          drain_d = drain_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_q     <= '0;
      wait_q    <= '0;
      mask_q    <= '0;
      act_q     <= '1;
      elapsed_q <= '0;
      drain_q   <= '0;
      cyc_q     <= '0;
      runs_q    <= '0;
      aborted_q <= 1'b0;
      rej_q     <= 1'b0;
      cfg_q     <= '0;
      res_q     <= '0;
    end else begin
      dur_q     <= dur_d;
      wait_q    <= wait_d;
      mask_q    <= mask_d;
      act_q     <= act_d;
      elapsed_q <= elapsed_d;
      drain_q   <= drain_d;
      cyc_q     <= cyc_d;
      runs_q    <= runs_d;
      aborted_q <= aborted_d;
      rej_q     <= rej_d;
      cfg_q     <= cfg_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (ra)
      REG_STATUS:    rd_mux = {27'd0, rej_q, aborted_q, state_q, busy};
      REG_DURATION:  rd_mux = u32_t'(dur_q);
      REG_WAIT:      rd_mux = u32_t'(wait_q);
      REG_PORT_MASK: rd_mux = u32_t'(mask_q);
      REG_ELAPSED:   rd_mux = u32_t'(elapsed_q);
      REG_RUN_COUNT: rd_mux = runs_q;
      default: begin
        for (int i = 0; i < TEST_PORT_NUM; i++) begin
          if (ra[9:8] == 2'b01 && ra[7:5] == 3'(i)) rd_mux = cfg_q[i][ra[4:2]];
          if (ra[9:8] == 2'b10 && ra[7:4] == 4'(i)) rd_mux = res_q[i][ra[3:2]];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= rd_mux;
  end
endmodule

// File: tb/tb_speed_test_sequencer.sv
// Directed bench for speed_test_sequencer with a 10-cycle millisecond.
module tb_speed_test_sequencer;
  import tester_common::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] gen_ready = '0, check_ready = '0;
  port_result_t [3:0] check_results = '0;
  logic [3:0] start, stop;
  port_config_t [3:0] port_config;

  int n_chk = 0;
  int n_err = 0;

  speed_test_sequencer_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  speed_test_sequencer #(
    .TEST_PORT_NUM(4), .CLOCK_FREQ(10000),
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus),
    .gen_ready(gen_ready), .check_ready(check_ready), .check_results(check_results),
    .start(start), .stop(stop), .port_config(port_config)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] st);
    int n;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("aw_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("b_timeout", 32'(n), 32'd0);
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ar_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("r_timeout", 32'(n), 32'd0);
    d = bus.rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    int n;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state; ports not ready so the FSM must hold in WAIT_READY.
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_stop", 32'(stop), 32'd0);
    rst = 1'b0;
    rd_chk("status_wait_ready", 10'h000, 32'h1);
    rd_chk("duration_rst", 10'h008, 32'h0);
    gen_ready = 4'hF; check_ready = 4'hF;
    repeat (2) @(negedge clk);
    rd_chk("status_idle", 10'h000, 32'h2);

    // Rejected starts: zero duration, then zero mask.
    axi_write(10'h004, 32'h1, 4'hF);
    rd_chk("rej_dur0", 10'h000, 32'h12);
    axi_write(10'h008, 32'h3, 4'hF);
    axi_write(10'h004, 32'h1, 4'hF);
    rd_chk("rej_mask0", 10'h000, 32'h12);

    // Byte strobes in IDLE.
    axi_write(10'h128, 32'hAABBCCDD, 4'hF);
    axi_write(10'h128, 32'h11223344, 4'b0101);
    rd_chk("cfg_strb", 10'h128, 32'hAA22CC44);
    chk("cfg_port_out", port_config[1][2], 32'hAA22CC44);
    axi_write(10'h008, 32'h0000FF07, 4'b0001);
    rd_chk("dur_strb", 10'h008, 32'h7);
    axi_write(10'h008, 32'h3, 4'hF);

    // Run 1: 3 ms on ports 0 and 2, 2 ms drain.
    axi_write(10'h00C, 32'h2, 4'hF);
    axi_write(10'h010, 32'h5, 4'hF);
    check_results[0][0] = 32'hAAAA;
    check_results[1][0] = 32'h5555;
    check_results[2][0] = 32'h1234;
    check_results[3][0] = 32'h0077;
    axi_write(10'h004, 32'h1, 4'hF);
    chk("start_on", 32'(start), 32'h5);
    n = 0;
    while (start == 4'h5 && n < 100) begin n++; @(negedge clk); end
    chk("run_cycles", 32'(n), 32'd30);
    chk("stop_on", 32'(stop), 32'h5);
    chk("start_off", 32'(start), 32'h0);
    n = 0;
    while (stop == 4'h5 && n < 100) begin n++; @(negedge clk); end
    chk("drain_cycles", 32'(n), 32'd20);
    rd_chk("run_count1", 10'h018, 32'h1);
    rd_chk("elapsed1", 10'h014, 32'h3);
    rd_chk("status_after1", 10'h000, 32'h2);
    rd_chk("res_p2", 10'h220, 32'h1234);
    rd_chk("res_p0", 10'h200, 32'hAAAA);
    rd_chk("res_p1_disabled", 10'h210, 32'h0);

    // Run 2: writes while busy are dropped, then abort.
    axi_write(10'h008, 32'h5, 4'hF);
    axi_write(10'h004, 32'h1, 4'hF);
    rd_chk("status_running", 10'h000, 32'h5);
    axi_write(10'h008, 32'h9, 4'hF);
    rd_chk("dur_frozen", 10'h008, 32'h5);
    axi_write(10'h128, 32'hDEADBEEF, 4'hF);
    rd_chk("cfg_frozen", 10'h128, 32'hAA22CC44);
    axi_write(10'h004, 32'h2, 4'hF);
`ifdef SPEED_TEST_ABORT_EN
    chk("abort_stop", 32'(stop), 32'h5);
    chk("abort_start", 32'(start), 32'h0);
    rd_chk("status_aborted", 10'h000, 32'hF);
    n = 0;
    while (stop != 4'h0 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) chk("abort_drain_timeout", 32'(n), 32'd0);
    rd_chk("run_count_abort", 10'h018, 32'h1);
    rd_chk("status_after_abort", 10'h000, 32'hA);
`else
    chk("noabort_start", 32'(start), 32'h5);
    n = 0;
    while ((start != 4'h0 || stop != 4'h0) && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk("run2_timeout", 32'(n), 32'd0);
    rd_chk("run_count2", 10'h018, 32'h2);
    rd_chk("status_after2", 10'h000, 32'h2);
`endif

    // Run 3: reset in the middle of DRAINING.
    axi_write(10'h008, 32'h1, 4'hF);
    axi_write(10'h00C, 32'h5, 4'hF);
    axi_write(10'h004, 32'h1, 4'hF);
    n = 0;
    while (stop != 4'h5 && n < 50) begin n++; @(negedge clk); end
    chk("drain_reached", 32'(stop), 32'h5);
    repeat (3) @(negedge clk);
    gen_ready = 4'h0;
    rst = 1'b1;
    #1;
    chk("rst_async_stop", 32'(stop), 32'h0);
    chk("rst_async_start", 32'(start), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("status_post_rst", 10'h000, 32'h1);
    rd_chk("run_count_rst", 10'h018, 32'h0);
    rd_chk("mask_rst", 10'h010, 32'h0);
    rd_chk("wait_rst", 10'h00C, 32'h0);
    rd_chk("res_rst", 10'h220, 32'h0);
    rd_chk("cfg_rst", 10'h128, 32'h0);
    chk("cfg_out_rst", port_config[1][2], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
